uop_fill: RTL and testbench

Write-side counterpart of the micro-op buffer. It accepts a stream of decoded 32-bit instructions, each with its branch tag, and packs consecutive instructions in pairs into buffer entries. It then writes each entry into the uop buffer RAM at a circular head pointer. It compares the head pointer with the fetch stage's read address (`uop_addr`) to produce backpressure (`full`) and an "entry available" flag that drives fetch's `prev_valid`.

---
 rtl/uop_pkg.sv | 23 ++
 rtl/uop_fill_if.sv | 27 ++
 rtl/uop_fill.sv | 77 +++++++
 tb/tb_uop_fill.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/uop_pkg.sv
// Shared micro-op buffer parameters, entry field offsets and the entry packing helper.
// Used by the fill (write) side and by fetch for unpacking.
package uop_pkg;
    localparam int UOP_BUF_SIZE           = 128;
    localparam int UOP_ADDR_BITS          = $clog2(UOP_BUF_SIZE);
    localparam int MAX_PREDICT_DEPTH      = 3;
    localparam int MAX_PREDICT_DEPTH_BITS = $clog2(MAX_PREDICT_DEPTH);
    localparam int UOP_BUF_WIDTH          = 64 + 2 * MAX_PREDICT_DEPTH_BITS;
    localparam int UOP_TAG2_LSB           = 64;
    localparam int UOP_TAG1_LSB           = 64 + MAX_PREDICT_DEPTH_BITS;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef logic [MAX_PREDICT_DEPTH_BITS-1:0] uop_tag_t;
    typedef logic [UOP_ADDR_BITS-1:0]          uop_addr_t;
    typedef logic [UOP_BUF_WIDTH-1:0]          uop_entry_t;

    // i1 is the older instruction and lands in the low slot.
    function automatic uop_entry_t uop_pack(input logic [31:0] i1, input uop_tag_t t1,
                                            input logic [31:0] i2, input uop_tag_t t2);
        return {t1, t2, i2, i1};
    endfunction
endpackage

// File: rtl/uop_fill_if.sv
// Instruction stream in, buffer RAM write port out, occupancy flags back to fetch.
interface uop_fill_if;
    import uop_pkg::*;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    uop_tag_t    in_tag;
    logic        in_last;
    uop_addr_t   rd_addr;
    logic        wr_en;
    uop_addr_t   wr_addr;
    uop_entry_t  wr_data;
    logic        full;
    logic        buf_valid;
    logic        pending;

    modport master (
        output in_valid, in_instr, in_tag, in_last, rd_addr,
        input  in_ready, wr_en, wr_addr, wr_data, full, buf_valid, pending
    );

    modport slave (
        input  in_valid, in_instr, in_tag, in_last, rd_addr,
        output in_ready, wr_en, wr_addr, wr_data, full, buf_valid, pending
    );
endinterface

// File: rtl/uop_fill.sv
// Packs instruction pairs into uop buffer entries written at a circular head; write strobe
// registered one cycle after the completing accept. in_ready drops only when an emit would overrun.
module uop_fill
    import uop_pkg::*;
(
    input  logic     clk,
    input  logic     reset_n,
    input  logic     clear,
    uop_fill_if.slave u
);
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_HALF  = 1'b1;

    logic [0:0]  r_state;
    uop_addr_t   r_head;
    logic        r_wr_en;
    uop_addr_t   r_wr_addr;
    uop_entry_t  r_wr_data;
    logic [31:0] r_instr1;
    uop_tag_t    r_tag1;

    uop_addr_t w_head_inc;
    uop_addr_t w_committed;
    logic      w_full;
    logic      w_accept;

    // One slot stays unused so head == rd_addr always means empty.
    assign w_head_inc  = r_head + uop_addr_t'(1);
    assign w_full      = (w_head_inc == u.rd_addr);
    // The entry on the write port is not readable until the RAM captures it.
    assign w_committed = r_wr_en ? r_wr_addr : r_head;

    // A first half never writes, so it is taken even when the buffer is full.
    assign u.in_ready  = !clear && ((r_state == ST_HALF) ? !w_full : (!u.in_last || !w_full));
    assign w_accept    = u.in_valid && u.in_ready;

    assign u.full      = w_full;
    assign u.buf_valid = (w_committed != u.rd_addr);
    assign u.pending   = (r_state == ST_HALF);
    assign u.wr_en     = r_wr_en;
    assign u.wr_addr   = r_wr_addr;
    assign u.wr_data   = r_wr_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_EMPTY;
            r_head    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_instr1  <= '0;
            r_tag1    <= '0;
        end else if (clear) begin
            r_state <= ST_EMPTY;
            r_head  <= '0;
            r_wr_en <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            if (w_accept) begin
                if (r_state == ST_EMPTY && !u.in_last) begin
                    r_instr1 <= u.in_instr;
                    r_tag1   <= u.in_tag;
                    r_state  <= ST_HALF;
                end else begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_head;
                    r_head    <= w_head_inc;
                    r_state   <= ST_EMPTY;
                    if (r_state == ST_HALF)
                        r_wr_data <= uop_pack(r_instr1, r_tag1, u.in_instr, u.in_tag);
                    else
                        r_wr_data <= uop_pack(u.in_instr, u.in_tag, NOP_INSTR, '0);
                end
            end
        end
    end
endmodule

// File: tb/tb_uop_fill.sv
// Directed bench for uop_fill: per-cycle vector table plus full/stall, wrap and async reset sequences.
module tb_uop_fill;
    import uop_pkg::*;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic clear   = 1'b0;
    int   errs    = 0;
    int   checks  = 0;

    uop_fill_if u_if ();

    uop_fill dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .u       (u_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [31:0] instr;
        logic [1:0]  tag;
        logic        last;
        logic        clr;
        logic [6:0]  rd;
        logic        e_rdy;
        logic        e_wr;
        logic [6:0]  e_addr;
        logic [67:0] e_data;
        logic        e_full;
        logic        e_bv;
        logic        e_pend;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string nm, input logic [67:0] act, input logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        int          nwr;
        logic        rdy_ok;
        logic        no_wr;

        // Reset state, then the table walks pairing, in_last, HALF+in_last, read and clear.
        vt[0]  = '{1'b1, 32'h1111_1111, 2'd1, 1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 7'd0, 68'h0, 1'b0, 1'b0, 1'b1};
        vt[1]  = '{1'b1, 32'h2222_2222, 2'd2, 1'b0, 1'b0, 7'd0, 1'b1, 1'b1, 7'd0,
                   {2'd1, 2'd2, 32'h2222_2222, 32'h1111_1111}, 1'b0, 1'b0, 1'b0};
        vt[2]  = '{1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 7'd0, 68'h0, 1'b0, 1'b1, 1'b0};
        vt[3]  = '{1'b1, 32'hAAAA_0001, 2'd3, 1'b1, 1'b0, 7'd0, 1'b1, 1'b1, 7'd1,
                   {2'd3, 2'd0, 32'h0, 32'hAAAA_0001}, 1'b0, 1'b1, 1'b0};
        vt[4]  = '{1'b1, 32'h3333_3333, 2'd0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 7'd0, 68'h0, 1'b0, 1'b1, 1'b1};
        vt[5]  = '{1'b1, 32'h4444_4444, 2'd1, 1'b1, 1'b0, 7'd0, 1'b1, 1'b1, 7'd2,
                   {2'd0, 2'd1, 32'h4444_4444, 32'h3333_3333}, 1'b0, 1'b1, 1'b0};
        vt[6]  = '{1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 7'd3, 1'b1, 1'b0, 7'd0, 68'h0, 1'b0, 1'b0, 1'b0};
        vt[7]  = '{1'b1, 32'h5555_5555, 2'd1, 1'b0, 1'b0, 7'd3, 1'b1, 1'b0, 7'd0, 68'h0, 1'b0, 1'b0, 1'b1};
        vt[8]  = '{1'b1, 32'h6666_6666, 2'd2, 1'b0, 1'b1, 7'd0, 1'b0, 1'b0, 7'd0, 68'h0, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{1'b1, 32'h7777_7777, 2'd2, 1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 7'd0, 68'h0, 1'b0, 1'b0, 1'b1};
        vt[10] = '{1'b1, 32'h8888_8888, 2'd3, 1'b0, 1'b0, 7'd0, 1'b1, 1'b1, 7'd0,
                   {2'd2, 2'd3, 32'h8888_8888, 32'h7777_7777}, 1'b0, 1'b0, 1'b0};

        u_if.in_valid = 1'b0;
        u_if.in_instr = '0;
        u_if.in_tag   = '0;
        u_if.in_last  = 1'b0;
        u_if.rd_addr  = '0;

        #2;
        chk("rst_wr_en",     68'(u_if.wr_en),     68'(0));
        chk("rst_full",      68'(u_if.full),      68'(0));
        chk("rst_buf_valid", 68'(u_if.buf_valid), 68'(0));
        chk("rst_in_ready",  68'(u_if.in_ready),  68'(1));
        chk("rst_pending",   68'(u_if.pending),   68'(0));
        #10 reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            u_if.in_valid = vt[i].vld;
            u_if.in_instr = vt[i].instr;
            u_if.in_tag   = vt[i].tag;
            u_if.in_last  = vt[i].last;
            u_if.rd_addr  = vt[i].rd;
            clear         = vt[i].clr;
            #3;
            chk($sformatf("v%0d_in_ready", i), 68'(u_if.in_ready), 68'(vt[i].e_rdy));
            @(posedge clk); #1;
            chk($sformatf("v%0d_wr_en", i), 68'(u_if.wr_en), 68'(vt[i].e_wr));
            if (vt[i].e_wr) begin
                chk($sformatf("v%0d_wr_addr", i), 68'(u_if.wr_addr), 68'(vt[i].e_addr));
                chk($sformatf("v%0d_wr_data", i), 68'(u_if.wr_data), vt[i].e_data);
            end
            chk($sformatf("v%0d_full", i),      68'(u_if.full),      68'(vt[i].e_full));
            chk($sformatf("v%0d_buf_valid", i), 68'(u_if.buf_valid), 68'(vt[i].e_bv));
            chk($sformatf("v%0d_pending", i),   68'(u_if.pending),   68'(vt[i].e_pend));
        end
        clear = 1'b0;

        // Async reset with a half-entry held and a committed entry outstanding.
        u_if.in_valid = 1'b1;
        u_if.in_instr = 32'h9999_9999;
        u_if.in_last  = 1'b0;
        @(posedge clk); #1;
        u_if.in_valid = 1'b0;
        chk("pre_arst_pending",   68'(u_if.pending),   68'(1));
        chk("pre_arst_buf_valid", 68'(u_if.buf_valid), 68'(1));
        #3 reset_n = 1'b0;
        #1;
        chk("arst_pending",   68'(u_if.pending),   68'(0));
        chk("arst_wr_en",     68'(u_if.wr_en),     68'(0));
        chk("arst_wr_addr",   68'(u_if.wr_addr),   68'(0));
        chk("arst_wr_data",   68'(u_if.wr_data),   68'(0));
        chk("arst_full",      68'(u_if.full),      68'(0));
        chk("arst_buf_valid", 68'(u_if.buf_valid), 68'(0));
        chk("arst_in_ready",  68'(u_if.in_ready),  68'(1));
        #2 reset_n = 1'b1;

        // Fill until full with rd_addr held at 0.
        nwr    = 0;
        rdy_ok = 1'b1;
        u_if.in_valid = 1'b1;
        u_if.in_tag   = '0;
        for (int i = 0; i < 254; i++) begin
            u_if.in_instr = 32'(i);
            #1;
            if (!u_if.in_ready) rdy_ok = 1'b0;
            @(posedge clk); #1;
            if (u_if.wr_en) nwr++;
        end
        chk("fill_ready",     68'(rdy_ok),         68'(1));
        chk("fill_writes",    68'(nwr),            68'(127));
        chk("fill_full",      68'(u_if.full),      68'(1));
        chk("fill_buf_valid", 68'(u_if.buf_valid), 68'(1));

        u_if.in_instr = 32'd254;
        #1;
        chk("half_when_full_ready", 68'(u_if.in_ready), 68'(1));
        @(posedge clk); #1;
        chk("half_when_full_pending", 68'(u_if.pending), 68'(1));
        chk("half_when_full_wr_en",   68'(u_if.wr_en),   68'(0));

        u_if.in_instr = 32'd255;
        #1;
        chk("stall_ready", 68'(u_if.in_ready), 68'(0));
        no_wr = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (u_if.wr_en) no_wr = 1'b0;
        end
        chk("stall_no_write", 68'(no_wr),        68'(1));
        chk("stall_pending",  68'(u_if.pending), 68'(1));

        u_if.rd_addr = 7'd1;
        #1;
        chk("release_ready", 68'(u_if.in_ready), 68'(1));
        @(posedge clk); #1;
        u_if.in_valid = 1'b0;
        chk("release_wr_en",   68'(u_if.wr_en),   68'(1));
        chk("release_wr_addr", 68'(u_if.wr_addr), 68'(127));
        chk("release_wr_data", 68'(u_if.wr_data), {4'd0, 32'd255, 32'd254});
        chk("release_full",    68'(u_if.full),    68'(1));

        // Reader follows the writer across the 127 -> 0 boundary.
        u_if.rd_addr = 7'd127;
        @(posedge clk); #1;
        chk("wrap_full",      68'(u_if.full),      68'(0));
        chk("wrap_buf_valid", 68'(u_if.buf_valid), 68'(1));
        u_if.in_valid = 1'b1;
        u_if.in_last  = 1'b1;
        u_if.in_instr = 32'h0000_BBBB;
        u_if.in_tag   = 2'd1;
        @(posedge clk); #1;
        u_if.in_valid = 1'b0;
        u_if.in_last  = 1'b0;
        chk("wrap_wr_en",   68'(u_if.wr_en),   68'(1));
        chk("wrap_wr_addr", 68'(u_if.wr_addr), 68'(0));
        chk("wrap_wr_data", 68'(u_if.wr_data), {2'd1, 2'd0, 32'h0, 32'h0000_BBBB});
        u_if.rd_addr = 7'd1;
        #1;
        chk("wrap_bv_inflight", 68'(u_if.buf_valid), 68'(1));
        @(posedge clk); #1;
        chk("wrap_drained_bv",   68'(u_if.buf_valid), 68'(0));
        chk("wrap_drained_full", 68'(u_if.full),      68'(0));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
